// File: rtl/clock_time_ctrl_if.sv
// Button inputs and time/highlight outputs of clock_time_ctrl.
// master: board/bench side (drives buttons, reads time); slave: the controller.
interface clock_time_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] sec_u;
    logic [2:0] sec_d;
    logic [3:0] min_u;
    logic [2:0] min_d;
    logic [3:0] hrs_u;
    logic [1:0] hrs_d;
    logic       edit_hrs;
    logic       edit_min;
    logic       blink;
    logic       tick_1hz;

    modport master (
        output btn_mode, btn_inc,
        input  sec_u, sec_d, min_u, min_d, hrs_u, hrs_d,
        input  edit_hrs, edit_min, blink, tick_1hz
    );

    modport slave (
        input  btn_mode, btn_inc,
        output sec_u, sec_d, min_u, min_d, hrs_u, hrs_d,
        output edit_hrs, edit_min, blink, tick_1hz
    );
endinterface

// File: rtl/clock_time_ctrl.sv
// BCD time-of-day registers with 1 Hz prescaler, carry chain and a
// two-button (mode, inc) set-mode FSM. Single px_clk domain.
// Optional build macro AUTO_REPEAT_EN: held inc auto-repeats in set states.
module clock_time_ctrl #(
    parameter int TICKS_PER_SEC   = 31500000,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int REPEAT_CYCLES   = 8000000
) (
    input  logic              clk,
    input  logic              reset,
    clock_time_ctrl_if.slave  bus
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [6:0] BCD_59 = 7'h59;
    localparam logic [5:0] BCD_23 = 6'h23;

    if (TICKS_PER_SEC < 4 || (TICKS_PER_SEC % 2) != 0 ||
        DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("clock_time_ctrl: illegal parameter value");
    end

    typedef enum logic [1:0] {RUN, SET_HRS, SET_MIN} state_t;

    // Next value of a 00..59 BCD pair {tens[2:0], units[3:0]}, wrapping without carry-out.
    function automatic logic [6:0] bcd60_next(input logic [6:0] v);
        if (v[3:0] != 4'd9)      return {v[6:4], v[3:0] + 4'd1};
        else if (v[6:4] != 3'd5) return {v[6:4] + 3'd1, 4'd0};
        else                     return 7'd0;
    endfunction

    // Next value of a 00..23 BCD hour pair {tens[1:0], units[3:0]}.
    function automatic logic [5:0] hrs_next(input logic [5:0] v);
        if (v == BCD_23)         return 6'd0;
        else if (v[3:0] == 4'd9) return {v[5:4] + 2'd1, 4'd0};
        else                     return {v[5:4], v[3:0] + 4'd1};
    endfunction

    // ---------------- button path ----------------
    logic [1:0]    btn_raw;   // [0]=mode, [1]=inc
    logic [1:0]    sync1, sync2, deb, deb_q, press;
    logic [DW-1:0] deb_cnt [2];

    assign btn_raw = {bus.btn_inc, bus.btn_mode};

    // two-flop synchroniser per raw button
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // debounce: state flips after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_cnt[i] <= '0;
                    deb[i]     <= sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // press events only on the debounced rising edge
    assign press = deb & ~deb_q;

    logic   mode_ev, inc_ev;
    state_t state, state_nxt;

    assign mode_ev = press[0];

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    logic [RW-1:0] rep_cnt;
    logic          rep_ev;

    // counter is 0 in the press cycle, so repeats land REPEAT_CYCLES apart
    assign rep_ev = (rep_cnt == RW'(REPEAT_CYCLES));
    assign inc_ev = press[1] | rep_ev;

    // repeat timer runs only while inc is held in a set state
    always_ff @(posedge clk) begin
        if (reset || !deb[1] || state == RUN || state_nxt != state)
            rep_cnt <= '0;
        else if (rep_ev)
            rep_cnt <= RW'(1);
        else
            rep_cnt <= rep_cnt + 1'b1;
    end
`else
    assign inc_ev = press[1];
`endif

    // ---------------- mode FSM ----------------
    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // next state: mode events cycle RUN -> SET_HRS -> SET_MIN -> RUN
    always_comb begin
        state_nxt = state;
        if (mode_ev) begin
            case (state)
                RUN:     state_nxt = SET_HRS;
                SET_HRS: state_nxt = SET_MIN;
                SET_MIN: state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    // ---------------- time datapath ----------------
    logic [PW-1:0] cnt_q, cnt_n;
    logic [6:0]    sec_q, sec_n, min_q, min_n;
    logic [5:0]    hrs_q, hrs_n;
    logic          blink_q, blink_n, tick_q, tick_n;
    logic          last, half;

    assign last = (cnt_q == PW'(TICKS_PER_SEC - 1));
    assign half = (cnt_q == PW'(TICKS_PER_SEC / 2 - 1));

    // next time value: full ripple in RUN, field edits in set states
    always_comb begin
        cnt_n   = last ? '0 : cnt_q + 1'b1;
        sec_n   = sec_q;
        min_n   = min_q;
        hrs_n   = hrs_q;
        tick_n  = 1'b0;
        blink_n = blink_q ^ (half | last);
        case (state)
            RUN: begin
                if (last) begin
                    tick_n = 1'b1;
                    sec_n  = bcd60_next(sec_q);
                    if (sec_q == BCD_59) begin
                        min_n = bcd60_next(min_q);
                        if (min_q == BCD_59) hrs_n = hrs_next(hrs_q);
                    end
                end
            end
            SET_HRS: begin
                if (inc_ev && !mode_ev) hrs_n = hrs_next(hrs_q);
            end
            SET_MIN: begin
                // leaving: restart the second so the first tick is a full second away
                if (mode_ev) begin
                    sec_n = '0;
                    cnt_n = '0;
                end else if (inc_ev) begin
                    min_n = bcd60_next(min_q);
                end
            end
            default: ;
        endcase
    end

    // time, prescaler, blink and tick registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hrs_q   <= '0;
            blink_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_n;
            sec_q   <= sec_n;
            min_q   <= min_n;
            hrs_q   <= hrs_n;
            blink_q <= blink_n;
            tick_q  <= tick_n;
        end
    end

    assign bus.sec_u    = sec_q[3:0];
    assign bus.sec_d    = sec_q[6:4];
    assign bus.min_u    = min_q[3:0];
    assign bus.min_d    = min_q[6:4];
    assign bus.hrs_u    = hrs_q[3:0];
    assign bus.hrs_d    = hrs_q[5:4];
    assign bus.edit_hrs = (state == SET_HRS);
    assign bus.edit_min = (state == SET_MIN);
    assign bus.blink    = blink_q;
    assign bus.tick_1hz = tick_q;
endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl (TICKS_PER_SEC=10, DEBOUNCE_CYCLES=4,
// REPEAT_CYCLES=6). Tick results are checked by a scoreboard queue or by a
// seconds-since-midnight model of the time of day.
`timescale 1ns/1ps
module tb_clock_time_ctrl;
    localparam int T = 10;
    localparam int D = 4;
    localparam int R = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;

    clock_time_ctrl_if bus();

    clock_time_ctrl #(
        .TICKS_PER_SEC(T), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] t;
        int          gap;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   ref_cyc = 0;
    int   m_time = 0;   // model time, seconds since midnight
    bit   track = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] digits(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [19:0] obs();
        return {bus.hrs_d, bus.hrs_u, bus.min_d, bus.min_u, bus.sec_d, bus.sec_u};
    endfunction

    function automatic bit in_range(input logic [19:0] v);
        if ($isunknown(v)) return 1'b0;
        return (v[3:0] <= 9) && (v[6:4] <= 5) && (v[10:7] <= 9) && (v[13:11] <= 5) &&
               (v[17:14] <= 9) && (v[19:18] <= 2) && !(v[19:18] == 2 && v[17:14] > 3);
    endfunction

    // tick monitor: pops the scoreboard, otherwise advances the model
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && bus.tick_1hz === 1'b1) begin
            n_cmp++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (obs() !== e.t) begin
                    n_err++;
                    $display("FAIL tick_time: got %h want %h", obs(), e.t);
                end
                if (e.gap != 0 && (cyc - ref_cyc) != e.gap) begin
                    n_err++;
                    $display("FAIL tick_spacing: got %0d want %0d", cyc - ref_cyc, e.gap);
                end
                ref_cyc = cyc;
            end else if (track) begin
                m_time = (m_time + 1) % 86400;
                if (obs() !== digits(m_time)) begin
                    n_err++;
                    $display("FAIL tick_model: got %h want %h", obs(), digits(m_time));
                end
            end else begin
                n_err++;
                $display("FAIL tick_unexpected: got tick at cycle %0d want none", cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        ref_cyc = cyc;
        m_time = 0;
        sb.delete();
    endtask

    task automatic press(input bit is_inc);
        if (is_inc) bus.btn_inc = 1'b1;
        else        bus.btn_mode = 1'b1;
        repeat (12) @(negedge clk);
        bus.btn_inc  = 1'b0;
        bus.btn_mode = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic model_inc_min();
        int m;
        m = (m_time / 60) % 60;
        m_time = m_time + (((m + 1) % 60) - m) * 60;
    endtask

    task automatic set_hrs(input int h);
        while ((m_time / 3600) != h) begin
            press(1'b1);
            m_time = (m_time + 3600) % 86400;
        end
    endtask

    task automatic set_min(input int m);
        while (((m_time / 60) % 60) != m) begin
            press(1'b1);
            model_inc_min();
        end
    endtask

    task automatic test_reset();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp += 5;
        if (obs() !== 20'd0) begin n_err++; $display("FAIL reset_time: got %h want 0", obs()); end
        if (bus.edit_hrs !== 1'b0) begin n_err++; $display("FAIL reset_edit_hrs: got %b want 0", bus.edit_hrs); end
        if (bus.edit_min !== 1'b0) begin n_err++; $display("FAIL reset_edit_min: got %b want 0", bus.edit_min); end
        if (bus.blink !== 1'b0) begin n_err++; $display("FAIL reset_blink: got %b want 0", bus.blink); end
        if (bus.tick_1hz !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", bus.tick_1hz); end
    endtask

    task automatic test_run();
        int   toggles, bad_gap, last_t;
        logic pb;
        do_reset();
        track = 1'b0;
        for (int i = 1; i <= 60; i++) sb.push_back('{t: digits(i), gap: T});
        toggles = 0;
        bad_gap = 0;
        last_t  = ref_cyc;
        pb      = bus.blink;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus.blink !== pb) begin
                toggles++;
                if (cyc - last_t != T / 2) bad_gap++;
                last_t = cyc;
                pb = bus.blink;
            end
        end
        @(negedge clk);
        n_cmp += 4;
        if (sb.size() != 0) begin n_err++; $display("FAIL run_ticks_left: got %0d want 0", sb.size()); end
        if (obs() !== digits(60)) begin n_err++; $display("FAIL run_time: got %h want %h", obs(), digits(60)); end
        if (toggles != 120) begin n_err++; $display("FAIL blink_toggles: got %0d want 120", toggles); end
        if (bad_gap != 0) begin n_err++; $display("FAIL blink_period: got %0d bad gaps want 0", bad_gap); end
    endtask

    task automatic test_wrap();
        logic [19:0] prev, cur;
        bit          saw_midnight;
        do_reset();
        track = 1'b1;
        press(1'b0);
        set_hrs(23);
        press(1'b0);
        set_min(59);
        n_cmp++;
        if (obs() !== digits(23 * 3600 + 59 * 60 + (m_time % 60))) begin
            n_err++; $display("FAIL wrap_set: got %h want 23:59", obs());
        end
        m_time = m_time - (m_time % 60);
        press(1'b0);
        saw_midnight = 1'b0;
        prev = obs();
        for (int i = 0; i < 620; i++) begin
            @(negedge clk);
            cur = obs();
            n_cmp++;
            if (!in_range(cur)) begin n_err++; $display("FAIL digit_range: got %h at cycle %0d", cur, cyc); end
            if (prev == digits(86399) && cur == 20'd0) saw_midnight = 1'b1;
            prev = cur;
        end
        n_cmp++;
        if (saw_midnight !== 1'b1) begin n_err++; $display("FAIL midnight_wrap: got %b want 1", saw_midnight); end
    endtask

    task automatic test_bounce();
        int lat;
        do_reset();
        track = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.btn_mode = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        bus.btn_mode = 1'b1;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (lat < 0 && bus.edit_hrs === 1'b1) lat = i;
        end
        bus.btn_mode = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp += 3;
        if (lat < D + 2 || lat > D + 4) begin n_err++; $display("FAIL mode_latency: got %0d want %0d+/-1", lat, D + 3); end
        if (bus.edit_hrs !== 1'b1) begin n_err++; $display("FAIL bounce_edit_hrs: got %b want 1", bus.edit_hrs); end
        if (bus.edit_min !== 1'b0) begin n_err++; $display("FAIL bounce_edit_min: got %b want 0", bus.edit_min); end
    endtask

    task automatic test_set_path();
        int t_exit, gap;
        do_reset();
        track = 1'b1;
        press(1'b0);
        set_hrs(22);
        n_cmp++;
        if (obs() !== digits(m_time)) begin n_err++; $display("FAIL set_hrs22: got %h want %h", obs(), digits(m_time)); end
        press(1'b1);
        n_cmp++;
        if (obs()[19:14] !== 6'h23) begin n_err++; $display("FAIL set_hrs23: got %h want 23", obs()[19:14]); end
        press(1'b1);
        m_time = (m_time + 7200) % 86400;
        n_cmp++;
        if (obs()[19:14] !== 6'h00) begin n_err++; $display("FAIL set_hrs_wrap: got %h want 00", obs()[19:14]); end
        press(1'b0);
        n_cmp++;
        if (bus.edit_min !== 1'b1) begin n_err++; $display("FAIL edit_min: got %b want 1", bus.edit_min); end
        set_min(58);
        for (int i = 0; i < 3; i++) begin press(1'b1); model_inc_min(); end
        n_cmp += 2;
        if (obs()[13:7] !== 7'h01) begin n_err++; $display("FAIL set_min_wrap: got %h want 01", obs()[13:7]); end
        if (obs()[19:14] !== 6'h00) begin n_err++; $display("FAIL set_min_no_carry: got %h want 00", obs()[19:14]); end
        // leave SET_MIN and time the first tick from the exit edge
        m_time = m_time - (m_time % 60);
        bus.btn_mode = 1'b1;
        t_exit = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.edit_min === 1'b0) begin t_exit = cyc; break; end
        end
        n_cmp++;
        if (obs()[6:0] !== 7'h00) begin n_err++; $display("FAIL exit_sec: got %h want 00", obs()[6:0]); end
        gap = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.tick_1hz === 1'b1) begin gap = cyc - t_exit; break; end
        end
        n_cmp++;
        if (t_exit < 0 || gap != T) begin n_err++; $display("FAIL first_tick: got %0d want %0d", gap, T); end
        bus.btn_mode = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        do_reset();
        track = 1'b1;
        press(1'b0);
        press(1'b1);
        m_time = (m_time + 3600) % 86400;
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        repeat (12) @(negedge clk);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp += 3;
        if (bus.edit_min !== 1'b1) begin n_err++; $display("FAIL simul_state: got %b want 1", bus.edit_min); end
        if (bus.edit_hrs !== 1'b0) begin n_err++; $display("FAIL simul_edit_hrs: got %b want 0", bus.edit_hrs); end
        if (obs() !== digits(m_time)) begin n_err++; $display("FAIL simul_hrs: got %h want %h", obs(), digits(m_time)); end
        // reset in the middle of SET_MIN
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp += 4;
        if (obs() !== 20'd0) begin n_err++; $display("FAIL midreset_time: got %h want 0", obs()); end
        if (bus.edit_min !== 1'b0) begin n_err++; $display("FAIL midreset_edit: got %b want 0", bus.edit_min); end
        if (bus.blink !== 1'b0) begin n_err++; $display("FAIL midreset_blink: got %b want 0", bus.blink); end
        if (bus.tick_1hz !== 1'b0) begin n_err++; $display("FAIL midreset_tick: got %b want 0", bus.tick_1hz); end
        reset = 1'b0;
        ref_cyc = cyc;
        track = 1'b0;
        sb.push_back('{t: digits(1), gap: T});
        repeat (12) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin n_err++; $display("FAIL midreset_prescaler: got %0d pending want 0", sb.size()); end
        m_time = 1;
        track = 1'b1;
    endtask

    task automatic test_repeat();
        logic [6:0] start;
        int         n_inc;
        do_reset();
        track = 1'b1;
        press(1'b0);
        press(1'b0);
        start = obs()[13:7];
        bus.btn_inc = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (obs()[13:7] !== start) break;
        end
        repeat (20) @(negedge clk);
        bus.btn_inc = 1'b0;
        repeat (20) @(negedge clk);
`ifdef AUTO_REPEAT_EN
        n_inc = 5;
`else
        n_inc = 1;
`endif
        for (int i = 0; i < n_inc; i++) model_inc_min();
        n_cmp += 2;
        if (obs() !== digits(m_time)) begin n_err++; $display("FAIL held_inc: got %h want %h", obs(), digits(m_time)); end
        if (bus.edit_min !== 1'b1) begin n_err++; $display("FAIL held_inc_state: got %b want 1", bus.edit_min); end
    endtask

    initial begin
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        test_reset();
        test_run();
        test_wrap();
        test_bounce();
        test_set_path();
        test_simultaneous();
        test_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
